// File: rtl/dport_pkg.sv
// dport_pkg: shared constants and requester indices for the system data
// port arbiter.
//   DPORT_W        width of one data port byte
//   CAPTURE_DEPTH  size of the capture window used by the assembly harness
//   req_id_e       fixed requester slots used when wiring up the system
package dport_pkg;

  localparam int DPORT_W       = 8;
  localparam int CAPTURE_DEPTH = 256;

  typedef enum logic [2:0] {
    REQ_COMMIT = 3'd0,
    REQ_TRACE  = 3'd1,
    REQ_DEBUG  = 3'd2,
    REQ_AUX    = 3'd3
  } req_id_e;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: rotating-priority one-hot picker.
// The search starts at index ptr and wraps N-1 -> 0; the first set request
// wins. Purely combinational, so the caller owns the pointer state.
// Ports:
//   req     [N-1:0]      request vector
//   ptr     [PTR_W-1:0]  highest-priority index this cycle (must be < N)
//   gnt     [N-1:0]      one-hot grant, zero when no request
//   gnt_id  [PTR_W-1:0]  index of the granted request (0 when none)
//   gnt_any              any grant issued
module rr_arbiter
  import dport_pkg::*;
#(
  parameter int N     = 4,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [PTR_W-1:0] gnt_id,
  output logic             gnt_any
);

  always_comb begin
    int idx;
    idx     = 0;
    gnt     = '0;
    gnt_id  = '0;
    gnt_any = 1'b0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr) + i) % N;
      if (!gnt_any && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_id   = PTR_W'(idx);
        gnt_any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dport_arbiter.sv
// dport_arbiter: shares the system data output port among NREQ requesters.
// Round-robin grant, one registered output stage, sticky completion flag and
// a saturating emitted-byte counter.
// Optional build macro DPORT_ARB_LOCK_EN: a transfer with req_lock set keeps
// the grant on that requester until it transfers with req_lock clear.
// Without the macro req_lock is ignored.
// Ports:
//   clk, rst (async, active-low)
//   req_valid/req_data/req_lock/req_done  per-requester inputs
//   req_ready    one-hot accept
//   dport_out    registered byte, qualified by dport_write
//   done         sticky system completion
//   byte_count   saturating emitted-byte count, overflow sticky
//   grant_id     index of the last granted requester
module dport_arbiter
  import dport_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int CNT_W = 8,
  parameter int ID_W  = $clog2(NREQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [DPORT_W*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]         req_lock,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ-1:0]         req_done,
  output logic [DPORT_W-1:0]      dport_out,
  output logic                    dport_write,
  output logic                    done,
  output logic [CNT_W-1:0]        byte_count,
  output logic                    overflow,
  output logic [ID_W-1:0]         grant_id
);

  logic [NREQ-1:0] req_eff;
  logic [NREQ-1:0] lock_mask;
  logic [NREQ-1:0] done_lat;
  logic [NREQ-1:0] done_next;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] ptr_next;
  logic [ID_W-1:0] gnt_id_c;
  logic            gnt_any;
  logic            lock_free;

`ifdef DPORT_ARB_LOCK_EN
  logic lock_held;
  // While locked the pointer sits on the lock owner, so only it may win.
  assign lock_mask = lock_held ? (NREQ'(1) << rr_ptr) : '1;
  assign lock_free = ~lock_held;
`else
  logic unused_lock;
  assign unused_lock = ^req_lock;
  assign lock_mask   = '1;
  assign lock_free   = 1'b1;
`endif

  // Nothing is accepted in reset or once the system has completed.
  assign req_eff   = req_valid & lock_mask & {NREQ{rst & ~done}};
  assign done_next = done_lat | req_done;
  assign ptr_next  = (gnt_id_c == ID_W'(NREQ - 1)) ? '0 : gnt_id_c + ID_W'(1);

  rr_arbiter #(
    .N     (NREQ),
    .PTR_W (ID_W)
  ) u_rr (
    .req     (req_eff),
    .ptr     (rr_ptr),
    .gnt     (req_ready),
    .gnt_id  (gnt_id_c),
    .gnt_any (gnt_any)
  );

  // Stage boundary: accepted byte -> registered output port.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dport_out   <= '0;
      dport_write <= 1'b0;
      done        <= 1'b0;
      byte_count  <= '0;
      overflow    <= 1'b0;
      grant_id    <= '0;
      rr_ptr      <= '0;
      done_lat    <= '0;
`ifdef DPORT_ARB_LOCK_EN
      lock_held   <= 1'b0;
`endif
    end else begin
      dport_write <= gnt_any;
      done_lat    <= done_next;
      if (gnt_any) begin
        dport_out <= req_data[DPORT_W*gnt_id_c +: DPORT_W];
        grant_id  <= gnt_id_c;
        // Counted with the transfer so byte_count moves with dport_write.
        if (byte_count == '1) overflow <= 1'b1;
        else                  byte_count <= byte_count + CNT_W'(1);
`ifdef DPORT_ARB_LOCK_EN
        lock_held <= req_lock[gnt_id_c];
        rr_ptr    <= req_lock[gnt_id_c] ? gnt_id_c : ptr_next;
`else
        rr_ptr    <= ptr_next;
`endif
      end
      if (&done_next && (req_valid == '0) && !dport_write && lock_free)
        done <= 1'b1;
    end
  end

endmodule
